// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 key decoder
package ps2_pkg;

  // Frame receiver states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Scancode prefix bytes
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Bit positions inside the 11-bit key event word
  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  // A frame is good when the stop bit is high and data plus parity has odd weight
  function automatic logic ps2_frame_ok(input logic [7:0] data,
                                        input logic       parity,
                                        input logic       stop);
    return stop & (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - two-flop synchronizer plus run-length glitch filter
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic line_i,
  output logic level_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the filtered level; flip on the last one
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer and filter registers; the idle PS/2 line is high
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 frame receiver and key event builder (option: PS2_DECODER_TIMEOUT_EN)
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);

  logic clk_filt, data_filt;
  logic clk_prev_q;
  logic clk_fall, clk_edge;
  logic timeout_hit;

  ps2_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [10:0] key_q, key_d;
  logic        err_q, err_d;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .line_i  (ps2_clk_i),
    .level_o (clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .line_i  (ps2_data_i),
    .level_o (data_filt)
  );

  assign clk_fall = clk_prev_q & ~clk_filt;
  assign clk_edge = clk_prev_q ^ clk_filt;

`ifdef PS2_DECODER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Idle-clock watchdog: restarts on any filtered clock edge, runs only mid-frame
  always_comb begin
    tmo_d = tmo_q;
    if (clk_edge || (state_q == ST_IDLE)) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign timeout_hit = (state_q != ST_IDLE) && !clk_edge &&
                       (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;

  assign unused_timeout = clk_edge ^ (^TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  // Frame FSM next state, prefix tracking and key event construction
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    key_d     = key_q;
    err_d     = 1'b0;

    if (clk_fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_filt) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_filt, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = data_filt;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (ps2_frame_ok(shift_q, parity_q, data_filt)) begin
            if (shift_q == PS2_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
              brk_d = 1'b1;
            end else begin
              key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
              key_d[KEY_PRESSED] = ~brk_q;
              key_d[KEY_EXT]     = ext_q;
              key_d[7:0]         = shift_q;
              ext_d              = 1'b0;
              brk_d              = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end
  end

  // State and output registers; reset abandons any frame without flagging it
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_q      <= 11'h000;
      err_q      <= 1'b0;
    end else begin
      clk_prev_q <= clk_filt;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      key_q      <= key_d;
      err_q      <= err_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 12000;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk_i = 1'b1;
  logic        ps2_data_i = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int fails = 0;
  int err_cycles = 0;
  int key_changes = 0;
  logic [10:0] prev_key = 11'h000;

  ps2_key_decoder #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_key    (ps2_key),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Event monitors sampled away from the active edge
  always @(negedge clk_sys) begin
    if (frame_err === 1'b1) err_cycles++;
    if (ps2_key !== prev_key) key_changes++;
    prev_key <= ps2_key;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data_i = b;
    wait_cycles(10);
    ps2_clk_i = 1'b0;
    wait_cycles(20);
    ps2_clk_i = 1'b1;
    wait_cycles(10);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic flip_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ flip_par);
    send_bit(stop);
    ps2_data_i = 1'b1;
    wait_cycles(30);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(2);
    @(negedge clk_sys);
    checks++; if (ps2_key !== 11'h000) begin fails++; $display("FAIL reset_key: got %h expected %h", ps2_key, 11'h000); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_make;
    int e0, k0;
    e0 = err_cycles; k0 = key_changes;
    send_bit(1'b0);
    @(negedge clk_sys);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL make_busy: got %b expected 1", busy); end
    for (int i = 0; i < 8; i++) send_bit(i == 0 || i == 3 || i == 5);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_cycles(30);
    @(negedge clk_sys);
    checks++; if (ps2_key !== 11'h629) begin fails++; $display("FAIL make_key: got %h expected %h", ps2_key, 11'h629); end
    checks++; if (err_cycles != e0) begin fails++; $display("FAIL make_err: got %0d err cycles expected 0", err_cycles - e0); end
    checks++; if (key_changes != k0 + 1) begin fails++; $display("FAIL make_events: got %0d expected 1", key_changes - k0); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL make_idle: got %b expected 0", busy); end
  endtask

  task automatic test_break;
    int k0;
    k0 = key_changes;
    send_frame(8'hF0, 1'b0, 1'b1);
    @(negedge clk_sys);
    checks++; if (ps2_key !== 11'h629) begin fails++; $display("FAIL break_prefix_key: got %h expected %h", ps2_key, 11'h629); end
    send_frame(8'h29, 1'b0, 1'b1);
    @(negedge clk_sys);
    checks++; if (ps2_key !== 11'h029) begin fails++; $display("FAIL break_key: got %h expected %h", ps2_key, 11'h029); end
    checks++; if (key_changes != k0 + 1) begin fails++; $display("FAIL break_events: got %0d expected 1", key_changes - k0); end
  endtask

  task automatic test_extended;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h14, 1'b0, 1'b1);
    @(negedge clk_sys);
    checks++; if (ps2_key !== 11'h714) begin fails++; $display("FAIL ext_key: got %h expected %h", ps2_key, 11'h714); end
    send_frame(8'h14, 1'b0, 1'b1);
    @(negedge clk_sys);
    checks++; if (ps2_key !== 11'h214) begin fails++; $display("FAIL ext_cleared_key: got %h expected %h", ps2_key, 11'h214); end
  endtask

  task automatic test_parity_error;
    int e0;
    e0 = err_cycles;
    send_frame(8'h29, 1'b1, 1'b1);
    @(negedge clk_sys);
    checks++; if (err_cycles != e0 + 1) begin fails++; $display("FAIL parity_err_cycles: got %0d expected 1", err_cycles - e0); end
    checks++; if (ps2_key !== 11'h214) begin fails++; $display("FAIL parity_key_held: got %h expected %h", ps2_key, 11'h214); end
    e0 = err_cycles;
    send_frame(8'h29, 1'b0, 1'b0);
    @(negedge clk_sys);
    checks++; if (err_cycles != e0 + 1) begin fails++; $display("FAIL stop_err_cycles: got %0d expected 1", err_cycles - e0); end
    checks++; if (ps2_key !== 11'h214) begin fails++; $display("FAIL stop_key_held: got %h expected %h", ps2_key, 11'h214); end
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h29, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    @(negedge clk_sys);
    checks++; if (ps2_key !== 11'h61C) begin fails++; $display("FAIL err_clears_ext: got %h expected %h", ps2_key, 11'h61C); end
  endtask

  task automatic test_glitch;
    logic busy_seen;
    busy_seen = 1'b0;
    ps2_data_i = 1'b0;
    wait_cycles(15);
    ps2_clk_i = 1'b0;
    wait_cycles(FILTER_LEN - 2);
    ps2_clk_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    ps2_data_i = 1'b1;
    wait_cycles(20);
    checks++; if (busy_seen !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b expected 0", busy_seen); end
    checks++; if (ps2_key !== 11'h61C) begin fails++; $display("FAIL glitch_key: got %h expected %h", ps2_key, 11'h61C); end
  endtask

  task automatic test_reset_mid_frame;
    int e0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk_sys);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
    ps2_data_i = 1'b1;
    e0 = err_cycles;
    wait_cycles(1);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(40);
    @(negedge clk_sys);
    checks++; if (ps2_key !== 11'h000) begin fails++; $display("FAIL midreset_key: got %h expected %h", ps2_key, 11'h000); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (err_cycles != e0) begin fails++; $display("FAIL midreset_err: got %0d err cycles expected 0", err_cycles - e0); end
    send_frame(8'h29, 1'b0, 1'b1);
    @(negedge clk_sys);
    checks++; if (ps2_key !== 11'h629) begin fails++; $display("FAIL midreset_next_key: got %h expected %h", ps2_key, 11'h629); end
  endtask

`ifdef PS2_DECODER_TIMEOUT_EN
  task automatic test_timeout;
    int  e0;
    logic seen;
    seen = 1'b0;
    e0 = err_cycles;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    for (int i = 0; i < TIMEOUT_CYCLES + 200 && !seen; i++) begin
      @(negedge clk_sys);
      if (frame_err === 1'b1) seen = 1'b1;
    end
    wait_cycles(5);
    @(negedge clk_sys);
    checks++; if (seen !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b expected 1", seen); end
    checks++; if (err_cycles != e0 + 1) begin fails++; $display("FAIL timeout_err_cycles: got %0d expected 1", err_cycles - e0); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy: got %b expected 0", busy); end
    checks++; if (ps2_key !== 11'h629) begin fails++; $display("FAIL timeout_key_held: got %h expected %h", ps2_key, 11'h629); end
    send_frame(8'h1C, 1'b0, 1'b1);
    @(negedge clk_sys);
    checks++; if (ps2_key !== 11'h21C) begin fails++; $display("FAIL timeout_next_key: got %h expected %h", ps2_key, 11'h21C); end
  endtask
`endif

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity_error();
    test_glitch();
    test_reset_mid_frame();
`ifdef PS2_DECODER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
